// File: rtl/theremin_sensor_pkg.sv
// Shared definitions for the theremin sensor path.
//   FINE_BITS            : number of sub-cycle bits produced by the
//                          oversampling ISERDES bit detector (64 samples/cycle)
//   period_meter_state_t : state encoding of the edge period meter
//   fine_ts_t()          : returns the width of a fine timestamp
//                          ({coarse counter, bit index}) for a given counter width
package theremin_sensor_pkg;

    localparam int FINE_BITS = 6;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FIRST = 2'd1,
        MEASURE    = 2'd2
    } period_meter_state_t;

    // Width helper: a fine timestamp is the coarse counter with the
    // bit index appended as the least significant bits.
    function automatic int fine_ts_t(input int counter_bits);
        return counter_bits + FINE_BITS;
    endfunction

endpackage

// File: rtl/oversampling_edge_timestamper.sv
// Converts the bit detector edge stream into fine timestamps.
// Ports:
//   CLK_PARALLEL  : parallel clock
//   RESET         : synchronous active-high reset
//   CE            : enable; while low the counter and phase are held at 0
//   CHANGED_FLAG  : edge present this cycle
//   CHANGED_BIT   : index of the first changed bit, valid with CHANGED_FLAG
//   ts            : {coarse counter, CHANGED_BIT} for the current cycle
//   is_rising     : polarity of the edge in this cycle (from phase tracking)
//   edge_valid    : CHANGED_FLAG qualified by CE
module oversampling_edge_timestamper
    import theremin_sensor_pkg::*;
#(
    parameter int COUNTER_BITS = 16
) (
    input  logic                                 CLK_PARALLEL,
    input  logic                                 RESET,
    input  logic                                 CE,
    input  logic                                 CHANGED_FLAG,
    input  logic [FINE_BITS-1:0]                 CHANGED_BIT,
    output logic [fine_ts_t(COUNTER_BITS)-1:0]   ts,
    output logic                                 is_rising,
    output logic                                 edge_valid
);

    logic [COUNTER_BITS-1:0] cnt_reg;
    logic                    phase_reg;

    // The bit detector restarts at low level whenever CE drops, so the
    // first edge after enable is always rising: phase restarts at 0 too.
    always_ff @(posedge CLK_PARALLEL) begin
        if (RESET || !CE) begin
            cnt_reg   <= '0;
            phase_reg <= 1'b0;
        end else begin
            cnt_reg <= cnt_reg + COUNTER_BITS'(1);
            if (CHANGED_FLAG) begin
                phase_reg <= ~phase_reg;
            end
        end
    end

    assign ts         = {cnt_reg, CHANGED_BIT};
    assign is_rising  = ~phase_reg;
    assign edge_valid = CHANGED_FLAG & CE;

endmodule

// File: rtl/oversampling_edge_period_meter.sv
// Measures period (rising to rising) and high time (rising to falling) of
// the sensor signal at 1/64-cycle resolution from bit detector edges.
// Ports:
//   CLK_PARALLEL  : 200 MHz parallel clock
//   RESET         : synchronous active-high reset
//   CE            : enable (same signal as the bit detector enable)
//   CHANGED_FLAG  : edge present this cycle
//   CHANGED_BIT   : index of the first changed bit
//   PERIOD_VALID  : one-cycle pulse, PERIOD/HIGH_TIME updated
//   PERIOD        : rising-to-rising interval, 1/64 cycle units
//   HIGH_TIME     : rising-to-falling interval, 1/64 cycle units
//   TIMEOUT       : one-cycle pulse when the signal is lost
// Configuration macro: THEREMIN_PERIOD_TIMEOUT_EN enables the loss-of-signal
// timeout; without it TIMEOUT is constant 0 and long periods alias.
module oversampling_edge_period_meter
    import theremin_sensor_pkg::*;
#(
    parameter int COUNTER_BITS   = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                                CLK_PARALLEL,
    input  logic                                RESET,
    input  logic                                CE,
    input  logic                                CHANGED_FLAG,
    input  logic [FINE_BITS-1:0]                CHANGED_BIT,
    output logic                                PERIOD_VALID,
    output logic [fine_ts_t(COUNTER_BITS)-1:0]  PERIOD,
    output logic [fine_ts_t(COUNTER_BITS)-1:0]  HIGH_TIME,
    output logic                                TIMEOUT
);

    localparam int TS_BITS = fine_ts_t(COUNTER_BITS);

    generate
        if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= (1 << COUNTER_BITS)) begin : g_bad_timeout
            $error("TIMEOUT_CYCLES must lie in 1 .. 2**COUNTER_BITS-1");
        end
    endgenerate

    logic [TS_BITS-1:0] ts;
    logic               is_rising;
    logic               edge_valid;

    oversampling_edge_timestamper #(
        .COUNTER_BITS (COUNTER_BITS)
    ) u_timestamper (
        .CLK_PARALLEL (CLK_PARALLEL),
        .RESET        (RESET),
        .CE           (CE),
        .CHANGED_FLAG (CHANGED_FLAG),
        .CHANGED_BIT  (CHANGED_BIT),
        .ts           (ts),
        .is_rising    (is_rising),
        .edge_valid   (edge_valid)
    );

    period_meter_state_t state_reg;
    logic [TS_BITS-1:0]  rise_ts_reg;
    logic [TS_BITS-1:0]  high_acc_reg;
    logic [TS_BITS-1:0]  period_reg;
    logic [TS_BITS-1:0]  high_time_reg;
    logic                period_valid_reg;

    wire rise_edge = edge_valid & is_rising;
    wire fall_edge = edge_valid & ~is_rising;

`ifdef THEREMIN_PERIOD_TIMEOUT_EN
    localparam logic [COUNTER_BITS-1:0] TIMEOUT_LAST = COUNTER_BITS'(TIMEOUT_CYCLES - 1);
    logic [COUNTER_BITS-1:0] to_cnt_reg;
    logic                    timeout_reg;
`endif

    // Differences are modulo 2^TS_BITS, so counter wrap between the two
    // timestamps needs no correction.
    always_ff @(posedge CLK_PARALLEL) begin
        if (RESET) begin
            state_reg        <= IDLE;
            rise_ts_reg      <= '0;
            high_acc_reg     <= '0;
            period_reg       <= '0;
            high_time_reg    <= '0;
            period_valid_reg <= 1'b0;
`ifdef THEREMIN_PERIOD_TIMEOUT_EN
            to_cnt_reg       <= '0;
            timeout_reg      <= 1'b0;
`endif
        end else begin
            period_valid_reg <= 1'b0;
`ifdef THEREMIN_PERIOD_TIMEOUT_EN
            timeout_reg      <= 1'b0;
`endif
            if (!CE) begin
                state_reg    <= IDLE;
                rise_ts_reg  <= '0;
                high_acc_reg <= '0;
`ifdef THEREMIN_PERIOD_TIMEOUT_EN
                to_cnt_reg   <= '0;
`endif
            end else begin
                case (state_reg)
                    IDLE: begin
                        state_reg <= WAIT_FIRST;
                    end
                    WAIT_FIRST: begin
                        // Falling edges here only advance phase (in the timestamper).
                        if (rise_edge) begin
                            rise_ts_reg <= ts;
                            state_reg   <= MEASURE;
`ifdef THEREMIN_PERIOD_TIMEOUT_EN
                            to_cnt_reg  <= '0;
`endif
                        end
                    end
                    MEASURE: begin
                        if (rise_edge) begin
                            // An edge in the expiry cycle wins over the timeout.
                            period_reg       <= ts - rise_ts_reg;
                            high_time_reg    <= high_acc_reg;
                            period_valid_reg <= 1'b1;
                            rise_ts_reg      <= ts;
`ifdef THEREMIN_PERIOD_TIMEOUT_EN
                            to_cnt_reg       <= '0;
`endif
                        end else begin
                            if (fall_edge) begin
                                high_acc_reg <= ts - rise_ts_reg;
                            end
`ifdef THEREMIN_PERIOD_TIMEOUT_EN
                            if (to_cnt_reg == TIMEOUT_LAST) begin
                                timeout_reg <= 1'b1;
                                to_cnt_reg  <= '0;
                                state_reg   <= WAIT_FIRST;
                            end else begin
                                to_cnt_reg <= to_cnt_reg + COUNTER_BITS'(1);
                            end
`endif
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

    assign PERIOD_VALID = period_valid_reg;
    assign PERIOD       = period_reg;
    assign HIGH_TIME    = high_time_reg;
`ifdef THEREMIN_PERIOD_TIMEOUT_EN
    assign TIMEOUT      = timeout_reg;
`else
    assign TIMEOUT      = 1'b0;
`endif

endmodule

// File: tb/tb_oversampling_edge_period_meter.sv
`timescale 1ns/1ps
module tb_oversampling_edge_period_meter;
    import theremin_sensor_pkg::*;

    localparam int CB = 16;
    localparam int TB = CB + 6;
    localparam int TO = 4096;

    logic          CLK_PARALLEL = 1'b0;
    logic          RESET        = 1'b1;
    logic          CE           = 1'b0;
    logic          CHANGED_FLAG = 1'b0;
    logic [5:0]    CHANGED_BIT  = 6'd0;
    logic          PERIOD_VALID;
    logic [TB-1:0] PERIOD;
    logic [TB-1:0] HIGH_TIME;
    logic          TIMEOUT;

    oversampling_edge_period_meter #(
        .COUNTER_BITS   (CB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .CLK_PARALLEL (CLK_PARALLEL),
        .RESET        (RESET),
        .CE           (CE),
        .CHANGED_FLAG (CHANGED_FLAG),
        .CHANGED_BIT  (CHANGED_BIT),
        .PERIOD_VALID (PERIOD_VALID),
        .PERIOD       (PERIOD),
        .HIGH_TIME    (HIGH_TIME),
        .TIMEOUT      (TIMEOUT)
    );

    always #5 CLK_PARALLEL = ~CLK_PARALLEL;

    int checks = 0;
    int passes = 0;
    int valid_seen = 0;
    int timeout_seen = 0;
    logic [CB-1:0] model_cnt = '0;

    typedef struct {
        logic [CB-1:0] r1c; logic [5:0] r1b;
        logic [CB-1:0] fc;  logic [5:0] fb;
        logic [CB-1:0] r2c; logic [5:0] r2b;
        int exp_p;
        int exp_h;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // One clock: drive inputs, let the edge sample them, look at outputs 1 ns later.
    task automatic tick(input logic f, input logic [5:0] b);
        CHANGED_FLAG = f;
        CHANGED_BIT  = b;
        @(posedge CLK_PARALLEL);
        #1;
        CHANGED_FLAG = 1'b0;
        CHANGED_BIT  = 6'd0;
        if (CE && !RESET) model_cnt = model_cnt + 1'b1;
        else              model_cnt = '0;
        if (PERIOD_VALID) valid_seen++;
        if (TIMEOUT)      timeout_seen++;
    endtask

    task automatic idle_until(input logic [CB-1:0] target);
        int n;
        n = 0;
        while (model_cnt != target && n < 70000) begin
            tick(1'b0, 6'd0);
            n++;
        end
        if (model_cnt != target) begin
            checks++;
            $display("FAIL idle_until: counter %0d, wanted %0d", model_cnt, target);
        end
    endtask

    task automatic restart();
        CE = 1'b0;
        tick(1'b0, 6'd0);
        CE = 1'b1;
        valid_seen   = 0;
        timeout_seen = 0;
    endtask

    initial begin
        int t_early, t_at, t_after;
        logic [TB-1:0] held_p, held_h;

        vecs[0] = '{16'd10,    6'd5,  16'd60,    6'd0,  16'd110, 6'd37, 6432, 3195};
        vecs[1] = '{16'd20,    6'd0,  16'd21,    6'd63, 16'd22,  6'd0,  128,  127};
        vecs[2] = '{16'd5,     6'd63, 16'd6,     6'd0,  16'd7,   6'd0,  65,   1};
        vecs[3] = '{16'd65530, 6'd0,  16'd65533, 6'd10, 16'd4,   6'd0,  640,  202};

        // Reset state
        RESET = 1'b1; CE = 1'b0;
        repeat (3) tick(1'b0, 6'd0);
        check("reset PERIOD_VALID", PERIOD_VALID, 0);
        check("reset PERIOD", PERIOD, 0);
        check("reset HIGH_TIME", HIGH_TIME, 0);
        check("reset TIMEOUT", TIMEOUT, 0);
        RESET = 1'b0;
        tick(1'b0, 6'd0);

        // Table-driven measurements
        for (int i = 0; i < 4; i++) begin
            restart();
            idle_until(vecs[i].r1c); tick(1'b1, vecs[i].r1b);
            check($sformatf("v%0d first rise valid", i), PERIOD_VALID, 0);
            idle_until(vecs[i].fc);  tick(1'b1, vecs[i].fb);
            check($sformatf("v%0d fall valid", i), PERIOD_VALID, 0);
            idle_until(vecs[i].r2c); tick(1'b1, vecs[i].r2b);
            check($sformatf("v%0d closing valid", i), PERIOD_VALID, 1);
            check($sformatf("v%0d PERIOD", i), PERIOD, vecs[i].exp_p);
            check($sformatf("v%0d HIGH_TIME", i), HIGH_TIME, vecs[i].exp_h);
            tick(1'b0, 6'd0);
            check($sformatf("v%0d valid drops", i), PERIOD_VALID, 0);
            check($sformatf("v%0d PERIOD held", i), PERIOD, vecs[i].exp_p);
            check($sformatf("v%0d pulse count", i), valid_seen, 1);
            $display("vec %0d: period=%0d high=%0d", i, PERIOD, HIGH_TIME);
        end

        // CE dropped for 3 cycles mid-measurement
        restart();
        idle_until(16'd10); tick(1'b1, 6'd0);
        idle_until(16'd20); tick(1'b1, 6'd0);
        CE = 1'b0;
        repeat (3) tick(1'b0, 6'd0);
        check("ce drop pulses", valid_seen, 0);
        check("ce drop PERIOD held", PERIOD, 640);
        CE = 1'b1;
        idle_until(16'd10); tick(1'b1, 6'd0);
        check("ce restore first rise valid", PERIOD_VALID, 0);
        idle_until(16'd30); tick(1'b1, 6'd0);
        idle_until(16'd50); tick(1'b1, 6'd0);
        check("ce restore valid", PERIOD_VALID, 1);
        check("ce restore PERIOD", PERIOD, 2560);
        check("ce restore HIGH_TIME", HIGH_TIME, 1280);
        check("ce restore pulse count", valid_seen, 1);
        $display("ce-drop: period=%0d high=%0d", PERIOD, HIGH_TIME);

        // Loss of signal: no rising edge for TO cycles after the last rise
        restart();
        idle_until(16'd10); tick(1'b1, 6'd0);
        t_early = 0; t_at = 0; t_after = 0;
        for (int i = 1; i <= TO + 1; i++) begin
            tick(i == 10, 6'd0);
            if (TIMEOUT && i < TO) t_early++;
            if (i == TO)     t_at    = TIMEOUT;
            if (i == TO + 1) t_after = TIMEOUT;
        end
        check("gap pulses", valid_seen, 0);
`ifdef THEREMIN_PERIOD_TIMEOUT_EN
        check("timeout early", t_early, 0);
        check("timeout at expiry", t_at, 1);
        check("timeout one cycle", t_after, 0);
        check("timeout count", timeout_seen, 1);
        tick(1'b1, 6'd0);
        check("after timeout first rise valid", PERIOD_VALID, 0);
        repeat (4) tick(1'b0, 6'd0);
        tick(1'b1, 6'd0);
        repeat (4) tick(1'b0, 6'd0);
        tick(1'b1, 6'd3);
        check("after timeout valid", PERIOD_VALID, 1);
        check("after timeout PERIOD", PERIOD, 643);
        check("after timeout HIGH_TIME", HIGH_TIME, 320);
        $display("timeout: period=%0d high=%0d", PERIOD, HIGH_TIME);
`else
        check("no timeout count", timeout_seen + t_early + t_at + t_after, 0);
        tick(1'b1, 6'd0);
        check("long period valid", PERIOD_VALID, 1);
        check("long PERIOD", PERIOD, 262272);
        check("long HIGH_TIME", HIGH_TIME, 640);
        $display("long gap: period=%0d high=%0d", PERIOD, HIGH_TIME);
`endif

        // RESET one cycle before the expected closing rise
        restart();
        idle_until(16'd10); tick(1'b1, 6'd0);
        idle_until(16'd20); tick(1'b1, 6'd0);
        idle_until(16'd29);
        RESET = 1'b1;
        tick(1'b0, 6'd0);
        RESET = 1'b0;
        check("mid reset PERIOD", PERIOD, 0);
        check("mid reset HIGH_TIME", HIGH_TIME, 0);
        tick(1'b1, 6'd0);
        repeat (3) tick(1'b0, 6'd0);
        check("mid reset pulses", valid_seen, 0);
        check("mid reset PERIOD_VALID", PERIOD_VALID, 0);
        check("mid reset PERIOD after", PERIOD, 0);
        check("mid reset HIGH_TIME after", HIGH_TIME, 0);
        check("mid reset TIMEOUT", TIMEOUT, 0);
        $display("mid reset: period=%0d high=%0d", PERIOD, HIGH_TIME);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/oversampling_edge_period_meter.md
# oversampling_edge_period_meter

Measures the input signal period and high time from the edge stream of the oversampling ISERDES bit detector, at 1/64-cycle resolution. Each CHANGED_FLAG/CHANGED_BIT pair becomes a fine timestamp: a coarse cycle counter concatenated with the 6-bit bit index. The block subtracts consecutive rising-edge timestamps to get the period, and subtracts rising from falling to get the high time. It sits directly downstream of the bit detector in the theremin sensor path and feeds the period filter.

## Interface
- COUNTER_BITS, 16, coarse cycle counter width
- TIMEOUT_CYCLES, 4096, cycles without a rising edge before a timeout; must be < 2^COUNTER_BITS
- CLK_PARALLEL  in  1  200 MHz parallel clock
- RESET  in  1  reset, synchronous to CLK_PARALLEL, active high
- CE  in  1  enable, same signal that drives the bit detector
- CHANGED_FLAG  in  1  edge present this cycle (from bit detector)
- CHANGED_BIT  in  6  index of the first changed bit, valid with CHANGED_FLAG
- PERIOD_VALID  out  1  one-cycle pulse; PERIOD and HIGH_TIME are updated
- PERIOD  out  COUNTER_BITS+6  rising-to-rising interval, units of 1/64 cycle
- HIGH_TIME  out  COUNTER_BITS+6  rising-to-falling interval, same units
- TIMEOUT  out  1  one-cycle pulse when the signal is lost

## Operation
- Coarse counter `cnt` increments every cycle while CE=1. It is cleared to 0 by RESET or CE=0, and wraps modulo 2^COUNTER_BITS.
- Timestamp ts = {cnt, CHANGED_BIT}. All differences are taken modulo 2^(COUNTER_BITS+6), so counter wrap needs no special handling.
- Edge polarity comes from a `phase` bit, not from the data.
  - The bit detector restarts at low level whenever CE is deasserted, so the first edge after enable is rising.
  - `phase` is 0 after RESET or CE=0 and toggles on every CHANGED_FLAG.
  - An edge seen with phase=0 is rising; an edge seen with phase=1 is falling.
- State machine:
  - IDLE: held while CE=0 or RESET. Goes to WAIT_FIRST when CE=1.
  - WAIT_FIRST: on a rising edge, store ts in `rise_ts` and go to MEASURE. Falling edges only toggle `phase`.
  - MEASURE, falling edge: `high_acc` <= ts − rise_ts.
  - MEASURE, rising edge:
    - PERIOD <= ts − rise_ts, HIGH_TIME <= high_acc, PERIOD_VALID pulses.
    - rise_ts <= ts.
    - Timeout counter clears.
  - Any state: CE=0 forces IDLE on the next cycle and clears phase, rise_ts, high_acc and the timeout counter.
- The first rising edge after entering MEASURE from WAIT_FIRST produces no output, because a full period is needed.

## Timing
- Reset values: PERIOD_VALID=0, PERIOD=0, HIGH_TIME=0, TIMEOUT=0. State=IDLE, cnt=0, phase=0.
- Latency: PERIOD_VALID is asserted in the cycle after the cycle in which CHANGED_FLAG is sampled for the closing rising edge.
- PERIOD and HIGH_TIME hold their values until the next PERIOD_VALID.
- The block has no backpressure. Consumers must accept every PERIOD_VALID pulse.
- Back-to-back CHANGED_FLAG on consecutive cycles is legal. Each one is processed, and phase toggles each cycle.
- A rising edge in the same cycle as timeout expiry is processed as an edge; the timeout is suppressed.
- RESET mid-measurement: all state returns to reset values on the next edge, and no output pulse is produced.

## Configuration
- THEREMIN_PERIOD_TIMEOUT_EN:
  - Defined: a timeout counter runs in MEASURE. When it reaches TIMEOUT_CYCLES without a rising edge:
    - TIMEOUT pulses for 1 cycle.
    - State goes to WAIT_FIRST.
    - phase is preserved.
  - Undefined: there is no timeout counter and TIMEOUT is tied to 0. MEASURE is left only through CE=0 or RESET. Periods longer than 2^COUNTER_BITS cycles alias silently.

## Structure
- Shared package `theremin_sensor_pkg` holds:
  - the FINE_BITS=6 constant;
  - the state enum `period_meter_state_t` (IDLE, WAIT_FIRST, MEASURE);
  - the `fine_ts_t` width helper.
- One natural sub-module, `oversampling_edge_timestamper`, contains the coarse counter, phase tracking, and ts/is_rising/edge_valid generation. The FSM and subtraction stay in the top module.

## Test plan
- Periodic edges with the rising edge at cnt=10, bit 5 and the next rising edge at cnt=110, bit 37 → PERIOD=100·64+32=6432, one PERIOD_VALID pulse.
- Falling edge at cnt=60, bit 0 between those rises → HIGH_TIME=50·64−5=3195.
- Counter wrap with COUNTER_BITS=16: rise at cnt=65530, bit 0, then rise at cnt=4, bit 0 → PERIOD=10·64=640.
- CE dropped for 3 cycles mid-MEASURE, then restored → no output. The first rise after restore produces no output; the second rise produces a correct PERIOD.
- With THEREMIN_PERIOD_TIMEOUT_EN and TIMEOUT_CYCLES=4096, no rising edge for 4096 cycles after the last rise → TIMEOUT pulses once and PERIOD_VALID stays 0. The next two rises yield a valid PERIOD.
- RESET asserted one cycle before an expected closing rise → PERIOD_VALID never pulses, and all outputs read 0.
